// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-input round-robin arbiter with a registered one-hot grant.
// A grant lasts until the owner signals DONE, drops its request, or has held
// the grant for MAXHOLD cycles while some other requester is waiting. Every
// grant is followed by at least one idle cycle before the next arbitration.
module rr_arbiter4 #(
   parameter int MAXHOLD = 16,
   parameter int CNTW    = 8
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [3:0]      REQ,
   input  logic            DONE,
   output logic [3:0]      GNT,
   output logic [1:0]      GIDX,
   output logic            BUSY,
   output logic            TIMEOUT
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   // Hold-counter limits. The counter saturates at MAXHOLD; the forced
   // release fires once it has reached MAXHOLD-1 at a clock edge.
   localparam logic [CNTW-1:0] HOLD_MAX  = CNTW'(MAXHOLD);
   localparam logic [CNTW-1:0] HOLD_LAST = (MAXHOLD == 0) ? '0 : CNTW'(MAXHOLD - 1);
   localparam bit              HOLD_EN   = (MAXHOLD != 0);

   logic [0:0]      state_q, state_d;
   logic [3:0]      gnt_q, gnt_d;
   logic [1:0]      gidx_q, gidx_d;
   logic            busy_q, busy_d;
   logic            timeout_q, timeout_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [CNTW-1:0] hcnt_q, hcnt_d;

   logic            win_valid;
   logic [1:0]      win_idx;
   logic [1:0]      cand;
   logic [3:0]      win_onehot;
   logic [3:0]      others_req;
   logic            owner_req;
   logic            normal_rel;
   logic            forced_rel;

   // Rotating priority search: walk offsets 3..0 from the pointer so the
   // smallest offset with an active request is the last (winning) write.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = 2'd0;
      cand      = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_q + 2'(k);
         if (REQ[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // One-hot decode of the winning index, one bit per requester.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_onehot
         assign win_onehot[gi] = (win_idx == 2'(gi));
      end
   endgenerate

   // Release qualifiers while a grant is active. The owner's own request is
   // masked out so only competing requesters can force a release. Once the
   // counter has saturated, a newly arriving competitor still forces release.
   always_comb begin
      owner_req  = REQ[gidx_q];
      others_req = REQ & ~gnt_q;
      normal_rel = DONE || !owner_req;
      forced_rel = HOLD_EN && (hcnt_q >= HOLD_LAST) && (others_req != 4'b0000);
   end

   // Next-state logic: arbitrate in IDLE, track hold time and release in GRANT.
   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gidx_d    = gidx_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      ptr_d     = ptr_q;
      hcnt_d    = hcnt_q;

      case (state_q)
         ST_IDLE: begin
            // DONE is deliberately ignored here.
            if (win_valid) begin
               state_d = ST_GRANT;
               gnt_d   = win_onehot;
               gidx_d  = win_idx;
               busy_d  = 1'b1;
               ptr_d   = win_idx + 2'd1;
               hcnt_d  = '0;
            end
         end
         ST_GRANT: begin
            if (normal_rel || forced_rel) begin
               state_d   = ST_IDLE;
               gnt_d     = 4'b0000;
               busy_d    = 1'b0;
               // A voluntary release wins over a coincident timeout.
               timeout_d = !normal_rel;
            end else if (hcnt_q < HOLD_MAX) begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 4'b0000;
         gidx_q    <= 2'b00;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
         ptr_q     <= 2'b00;
         hcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gidx_q    <= gidx_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
         ptr_q     <= ptr_d;
         hcnt_q    <= hcnt_d;
      end
   end

   assign GNT     = gnt_q;
   assign GIDX    = gidx_q;
   assign BUSY    = busy_q;
   assign TIMEOUT = timeout_q;

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAXHOLD, default 16, max consecutive GRANT cycles while another requester waits; 0 disables forced release.
REQ-002 Parameter: CNTW, default 8, hold-counter width; MAXHOLD SHALL be < 2**CNTW.
REQ-003 Port: CLK  input  1  sole clock, all state updates on rising edge.
REQ-004 Port: RST  input  1  asynchronous, active-high reset.
REQ-005 Port: REQ  input  4  per-requester request, level-sensitive, bit i = requester i.
REQ-006 Port: DONE  input  1  owner releases grant; sampled only in GRANT.
REQ-007 Port: GNT  output  4  registered one-hot grant, drives the SEL input of a one-hot 4-to-1 mux; all-zero when idle.
REQ-008 Port: GIDX  output  2  binary index of granted requester; valid only while BUSY=1.
REQ-009 Port: BUSY  output  1  high while a grant is active (GNT != 0).
REQ-010 Port: TIMEOUT  output  1  one-cycle pulse on forced release.

Function
REQ-011 Two states: IDLE and GRANT; GNT SHALL be all-zero in IDLE and exactly one-hot in GRANT.
REQ-012 Priority pointer PTR (2 bits): search order PTR, PTR+1, PTR+2, PTR+3 mod 4; first asserted REQ bit wins.
REQ-013 IDLE, REQ != 0 at edge: next cycle GRANT, GNT = one-hot winner, GIDX = winner, BUSY=1; latency exactly 1 cycle.
REQ-014 IDLE, REQ = 0: remain IDLE, outputs unchanged.
REQ-015 On each new grant to index i, PTR SHALL become (i+1) mod 4 on the same edge.
REQ-016 GRANT, release condition = DONE=1 OR REQ[GIDX]=0 OR forced release; on release edge, return to IDLE, GNT=0, BUSY=0.
REQ-017 At least one IDLE cycle (GNT=0) SHALL separate any two grants; no back-to-back grant on the release edge.
REQ-018 Hold counter HCNT: cleared to 0 on grant edge; increments each GRANT cycle, saturating at MAXHOLD.
REQ-019 Forced release: MAXHOLD != 0, HCNT = MAXHOLD-1, and (REQ with owner bit masked) != 0 at edge -> release as REQ-016, TIMEOUT=1 for the following cycle only.
REQ-020 With no other requester pending, owner SHALL keep the grant indefinitely; HCNT saturates, no TIMEOUT.
REQ-021 DONE and forced release on the same edge: normal release, TIMEOUT SHALL stay 0.
REQ-022 DONE asserted in IDLE SHALL be ignored.
REQ-023 REQ bits changing while in GRANT SHALL not change GNT except via REQ-016.
REQ-024 GNT, GIDX, BUSY, TIMEOUT SHALL be driven directly from flops (no combinational path from REQ/DONE).

Reset
REQ-025 RST=1 SHALL immediately (asynchronously) force: state IDLE, GNT=4'b0000, GIDX=2'b00, BUSY=0, TIMEOUT=0, PTR=0, HCNT=0.
REQ-026 Reset asserted mid-grant SHALL drop the grant without a TIMEOUT pulse; first arbitration after release uses PTR=0.
REQ-027 First rising edge with RST=0 SHALL perform normal IDLE evaluation.

Verification
REQ-028 Reset, REQ=4'b1111 -> cycle+1 GNT=0001, GIDX=0; DONE pulses -> GNT sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
REQ-029 PTR=2, REQ=4'b0011 -> GNT=0001 (wrap-around past 2,3), PTR becomes 1.
REQ-030 MAXHOLD=4, REQ=0001 held, no DONE, 20 cycles -> GNT=0001 throughout, TIMEOUT never 1.
REQ-031 MAXHOLD=4, owner 0 holds, REQ[2] asserted at grant -> release after 4 GRANT cycles, TIMEOUT=1 one cycle, next grant GNT=0100 one cycle later.
REQ-032 Owner drops REQ[GIDX] without DONE -> GNT=0 next cycle; DONE coincident with timeout -> TIMEOUT=0.
REQ-033 RST pulsed asynchronously while GNT=0100 -> GNT=0000, BUSY=0 before next edge; subsequent REQ=1100 -> GNT=0100.
